// File: rtl/sr_ff_bank_arbiter.sv
// Round-robin arbiter sharing one bank of SR flip-flops between NREQ requesters.
// Optional SR_CONFLICT_CNT_EN adds a saturating 8-bit count of conflicting commands.
module sr_ff_bank_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_set,
  input  logic [NREQ*WIDTH-1:0] req_clr,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       req_done,
  output logic [WIDTH-1:0]      s_out,
  output logic [WIDTH-1:0]      r_out,
  input  logic [WIDTH-1:0]      q_in,
  output logic                  busy,
  output logic                  err
`ifdef SR_CONFLICT_CNT_EN
  ,
  output logic [7:0]            conflict_cnt
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t          state, state_n;
  logic [HW-1:0]   hold_cnt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   g_idx;
  logic            conf_any;
  logic [WIDTH-1:0] set_eff, clr_eff;

  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [WIDTH-1:0] sel_set, sel_clr, sel_conf;
  logic            mismatch;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    int cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(rr_ptr) + k) % NREQ;
      if (!gnt_found && req_valid[IW'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(cand);
      end
    end
  end

  assign sel_set  = req_set[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_clr  = req_clr[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_conf = sel_set & sel_clr;
  assign mismatch = (|(set_eff & ~q_in)) | (|(clr_eff & q_in));

  // State register, hold counter and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rr_ptr   <= IW'(NREQ - 1);
      g_idx    <= '0;
    end else begin
      state <= state_n;
      if (state == DRIVE && hold_cnt != HOLD_LAST)
        hold_cnt <= hold_cnt + 1'b1;
      else
        hold_cnt <= '0;
      if (state == IDLE && gnt_found)
        g_idx <= gnt_idx;
      if (state == CHECK)
        rr_ptr <= g_idx;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (gnt_found) state_n = DRIVE;
      DRIVE:   if (hold_cnt == HOLD_LAST) state_n = CHECK;
      CHECK:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Command masks are captured at accept; conflicting bits are dropped from both drives
  always_ff @(posedge clk) begin
    if (state == IDLE && gnt_found) begin
      set_eff  <= sel_set & ~sel_conf;
      clr_eff  <= sel_clr & ~sel_conf;
      conf_any <= |sel_conf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_out <= '0;
      r_out <= '0;
    end else if (state_n == DRIVE) begin
      if (state == IDLE) begin
        s_out <= sel_set & ~sel_conf;
        r_out <= sel_clr & ~sel_conf;
      end
    end else begin
      s_out <= '0;
      r_out <= '0;
    end
  end

`ifdef SR_CONFLICT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      conflict_cnt <= '0;
    else if (state == CHECK && conf_any && conflict_cnt != 8'hFF)
      conflict_cnt <= conflict_cnt + 8'd1;
  end
`endif

  // Ready is combinational from IDLE, so it is also masked while reset is held
  always_comb begin
    req_ready = '0;
    req_done  = '0;
    busy      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_found && !rst)
          req_ready = NREQ'(1) << gnt_idx;
      end
      DRIVE: busy = 1'b1;
      CHECK: begin
        busy     = 1'b1;
        req_done = NREQ'(1) << g_idx;
        err      = conf_any | mismatch;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sr_ff_bank_arbiter.sv
// Directed testbench for sr_ff_bank_arbiter with a behavioural SR flip-flop bank on q_in.
module tb_sr_ff_bank_arbiter;

  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int HOLD_CYC = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_set;
  logic [NREQ*WIDTH-1:0] req_clr;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_done;
  logic [WIDTH-1:0]      s_out;
  logic [WIDTH-1:0]      r_out;
  logic [WIDTH-1:0]      q_in;
  logic                  busy;
  logic                  err;
`ifdef SR_CONFLICT_CNT_EN
  logic [7:0]            conflict_cnt;
`endif

  logic [WIDTH-1:0] bank_q;
  logic             qforce_en;
  logic [WIDTH-1:0] qforce_val;

  int checks = 0;
  int errors = 0;

  sr_ff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_set(req_set),
    .req_clr(req_clr),
    .req_ready(req_ready),
    .req_done(req_done),
    .s_out(s_out),
    .r_out(r_out),
    .q_in(q_in),
    .busy(busy),
    .err(err)
`ifdef SR_CONFLICT_CNT_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bank_q <= '0;
    else     bank_q <= (bank_q & ~r_out) | s_out;
  end

  assign q_in = qforce_en ? qforce_val : bank_q;

  always @(negedge clk) begin
    checks++;
    if ((s_out & r_out) !== '0) begin
      errors++;
      $display("FAIL sr_overlap: s_out=%h r_out=%h required no common bit", s_out, r_out);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    #2;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    req_set = '0;
    req_clr = '0;
    qforce_en = 1'b0;
    qforce_val = '0;
    cyc();
    cyc();
    checks++;
    if (req_ready !== 4'b0000 || req_done !== 4'b0000 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b done=%b busy=%b err=%b required 0", req_ready, req_done, busy, err);
    end
    checks++;
    if (s_out !== 8'h00 || r_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_sr: s=%h r=%h required 00", s_out, r_out);
    end
`ifdef SR_CONFLICT_CNT_EN
    checks++;
    if (conflict_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt: cnt=%0d required 0", conflict_cnt);
    end
`endif
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_ready: ready=%b required 0001", req_ready);
    end
    req_valid = '0;
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept: busy=%b required 0", busy);
    end
  endtask

  task automatic test_single_set();
    req_set[0*WIDTH +: WIDTH] = 8'h0F;
    req_clr[0*WIDTH +: WIDTH] = 8'h00;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: ready=%b busy=%b required 0001/0", req_ready, busy);
    end
    cyc();
    req_valid = '0;
    for (int i = 0; i < HOLD_CYC; i++) begin
      #1;
      checks++;
      if (s_out !== 8'h0F || r_out !== 8'h00 || busy !== 1'b1 || req_done !== 4'b0000) begin
        errors++;
        $display("FAIL single_drive%0d: s=%h r=%h busy=%b done=%b required 0F/00/1/0000", i, s_out, r_out, busy, req_done);
      end
      cyc();
    end
    checks++;
    if (req_done !== 4'b0001 || err !== 1'b0 || s_out !== 8'h00 || q_in !== 8'h0F || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_done: done=%b err=%b s=%h q=%h ready=%b required 0001/0/00/0F/0000", req_done, err, s_out, q_in, req_ready);
    end
    cyc();
    checks++;
    if (busy !== 1'b0 || req_done !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle: busy=%b done=%b required 0/0000", busy, req_done);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_set[i*WIDTH +: WIDTH] = 8'h01 << i;
      req_clr[i*WIDTH +: WIDTH] = 8'h00;
    end
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp = 4'b0001 << order[n];
      #1;
      checks++;
      if (req_ready !== exp) begin
        errors++;
        $display("FAIL rr_ready%0d: ready=%b required %b", n, req_ready, exp);
      end
      cyc();
      cyc();
      cyc();
      checks++;
      if (req_done !== exp || err !== 1'b0 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL rr_done%0d: done=%b err=%b ready=%b required %b/0/0000", n, req_done, err, req_ready, exp);
      end
      if (n == 4) req_valid = '0;
      cyc();
    end
  endtask

  task automatic test_conflict();
    req_set[1*WIDTH +: WIDTH] = 8'hF0;
    req_clr[1*WIDTH +: WIDTH] = 8'h30;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL conf_ready: ready=%b required 0010", req_ready);
    end
    cyc();
    req_valid = '0;
    #1;
    checks++;
    if (s_out !== 8'hC0 || r_out !== 8'h00) begin
      errors++;
      $display("FAIL conf_drive: s=%h r=%h required C0/00", s_out, r_out);
    end
`ifdef SR_CONFLICT_CNT_EN
    checks++;
    if (conflict_cnt !== 8'd0) begin
      errors++;
      $display("FAIL conf_cnt_before: cnt=%0d required 0", conflict_cnt);
    end
`endif
    cyc();
    cyc();
    checks++;
    if (req_done !== 4'b0010 || err !== 1'b1) begin
      errors++;
      $display("FAIL conf_done: done=%b err=%b required 0010/1", req_done, err);
    end
    cyc();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL conf_err_pulse: err=%b required 0", err);
    end
`ifdef SR_CONFLICT_CNT_EN
    checks++;
    if (conflict_cnt !== 8'd1) begin
      errors++;
      $display("FAIL conf_cnt_after: cnt=%0d required 1", conflict_cnt);
    end
`endif
  endtask

  task automatic test_mismatch();
    req_set[2*WIDTH +: WIDTH] = 8'h01;
    req_clr[2*WIDTH +: WIDTH] = 8'h00;
    qforce_val = 8'h00;
    qforce_en = 1'b1;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL mis_ready: ready=%b required 0100", req_ready);
    end
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    checks++;
    if (req_done !== 4'b0100 || err !== 1'b1) begin
      errors++;
      $display("FAIL mis_done: done=%b err=%b required 0100/1", req_done, err);
    end
    cyc();
    qforce_en = 1'b0;
  endtask

  task automatic test_zero_and_clear();
    req_set[3*WIDTH +: WIDTH] = 8'h00;
    req_clr[3*WIDTH +: WIDTH] = 8'h00;
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL zero_ready: ready=%b required 1000", req_ready);
    end
    cyc();
    req_valid = '0;
    #1;
    checks++;
    if (s_out !== 8'h00 || r_out !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_drive: s=%h r=%h busy=%b required 00/00/1", s_out, r_out, busy);
    end
    cyc();
    cyc();
    checks++;
    if (req_done !== 4'b1000 || err !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b err=%b required 1000/0", req_done, err);
    end
    cyc();
    req_set[0*WIDTH +: WIDTH] = 8'h00;
    req_clr[0*WIDTH +: WIDTH] = 8'hFF;
    req_valid = 4'b0001;
    cyc();
    req_valid = '0;
    // Changing the masks after accept must not alter the command
    req_clr[0*WIDTH +: WIDTH] = 8'h00;
    #1;
    checks++;
    if (r_out !== 8'hFF || s_out !== 8'h00) begin
      errors++;
      $display("FAIL clr_drive: s=%h r=%h required 00/FF", s_out, r_out);
    end
    cyc();
    cyc();
    checks++;
    if (req_done !== 4'b0001 || err !== 1'b0 || q_in !== 8'h00) begin
      errors++;
      $display("FAIL clr_done: done=%b err=%b q=%h required 0001/0/00", req_done, err, q_in);
    end
    cyc();
  endtask

  task automatic test_async_reset();
    req_set[1*WIDTH +: WIDTH] = 8'hAA;
    req_clr[1*WIDTH +: WIDTH] = 8'h00;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL ar_ready: ready=%b required 0010", req_ready);
    end
    cyc();
    req_valid = '0;
    #1;
    checks++;
    if (s_out !== 8'hAA) begin
      errors++;
      $display("FAIL ar_drive: s=%h required AA", s_out);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (s_out !== 8'h00 || r_out !== 8'h00 || busy !== 1'b0 || req_done !== 4'b0000) begin
      errors++;
      $display("FAIL ar_clear: s=%h r=%h busy=%b done=%b required 00/00/0/0000", s_out, r_out, busy, req_done);
    end
    cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if (req_done !== 4'b0000 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ar_no_done: done=%b err=%b busy=%b required 0000/0/0", req_done, err, busy);
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL ar_next_grant: ready=%b required 0001", req_ready);
    end
    req_valid = '0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_round_robin();
    test_conflict();
    test_mismatch();
    test_zero_and_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
